// File: rtl/acumula_compara_n.sv
// acumula_compara_n: coin accumulator and price comparator with an inactivity timeout and a purchase handshake (optional TROCO_EN returns change on purchase)
module acumula_compara_n #(
  parameter int VALOR_W      = 6,
  parameter int MOEDA_W      = 3,
  parameter int PRECO_W      = 5,
  parameter int TEMPO_LIMITE = 100,
  parameter int TEMPO_W      = 7
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               rstC,
  input  logic               moeda_valida,
  input  logic [MOEDA_W-1:0] VM,
  input  logic               compra,
  input  logic [PRECO_W-1:0] vProduto,
  output logic               LP,
  output logic               DM,
  output logic               rejeita,
  output logic [VALOR_W-1:0] vTotal,
  output logic [VALOR_W-1:0] vTroco,
  output logic               ocupado
);
  typedef enum logic [1:0] {OCIOSO, ACUM, LIBERA, DEVOLVE} estado_t;
  estado_t estado, proxEstado;
  logic [TEMPO_W-1:0] timer, timerProx;
  logic [VALOR_W-1:0] totalProx, trocoProx, trocoLibera, precoExt;
  logic [VALOR_W:0] soma;
  logic moedaNova, compraOk, fimTempo, saida, cabe, aceitaMoeda, rejeitaProx;
  assign precoExt    = VALOR_W'(vProduto);
  assign soma        = {1'b0, vTotal} + (VALOR_W+1)'(VM);
  assign cabe        = ~soma[VALOR_W];
  assign moedaNova   = moeda_valida && (VM != '0);
  assign compraOk    = compra && (vProduto != '0) && (vTotal >= precoExt);
  assign fimTempo    = timer == TEMPO_W'(TEMPO_LIMITE - 1);
  assign saida       = rstC || compraOk || fimTempo;
  assign aceitaMoeda = moeda_valida && !saida && cabe;
`ifdef TROCO_EN
  logic [VALOR_W-1:0] preco;
  // latch the accepted price so LIBERA can compute the change
  always_ff @(posedge CLK or posedge rst)
    if (rst) preco <= '0;
    else if (estado == ACUM && !rstC && compraOk) preco <= precoExt;
  assign trocoLibera = vTotal - preco;
`else
  assign trocoLibera = '0;
`endif
  // state register
  always_ff @(posedge CLK or posedge rst)
    if (rst) estado <= OCIOSO;
    else estado <= proxEstado;
  // next state: in ACUM cancel beats purchase beats timeout
  always_comb begin
    proxEstado = OCIOSO;
    case (estado)
      OCIOSO:          proxEstado = moedaNova ? ACUM : OCIOSO;
      ACUM:            proxEstado = rstC ? DEVOLVE : compraOk ? LIBERA : fimTempo ? DEVOLVE : ACUM;
      LIBERA, DEVOLVE: proxEstado = OCIOSO;
    endcase
  end
  // next datapath values; a coin that cannot be credited this cycle is flagged for rejection
  always_comb begin
    totalProx   = vTotal;
    trocoProx   = vTroco;
    timerProx   = '0;
    rejeitaProx = 1'b0;
    case (estado)
      OCIOSO:  totalProx = moedaNova ? VALOR_W'(VM) : vTotal;
      ACUM: begin
        totalProx   = aceitaMoeda ? soma[VALOR_W-1:0] : vTotal;
        timerProx   = aceitaMoeda ? '0 : timer + TEMPO_W'(1);
        rejeitaProx = moeda_valida && !aceitaMoeda;
      end
      LIBERA: begin
        trocoProx   = trocoLibera;
        totalProx   = '0;
        rejeitaProx = moeda_valida;
      end
      DEVOLVE: begin
        trocoProx   = vTotal;
        totalProx   = '0;
        rejeitaProx = moeda_valida;
      end
    endcase
  end
  // registered outputs, decoded from the upcoming state so pulses align with LIBERA/DEVOLVE
  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      timer   <= '0;
      vTotal  <= '0;
      vTroco  <= '0;
      rejeita <= 1'b0;
      LP      <= 1'b0;
      DM      <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      timer   <= timerProx;
      vTotal  <= totalProx;
      vTroco  <= trocoProx;
      rejeita <= rejeitaProx;
      LP      <= proxEstado == LIBERA;
      DM      <= proxEstado == DEVOLVE;
      ocupado <= proxEstado != OCIOSO;
    end
endmodule

// File: tb/tb_acumula_compara_n.sv
// tb_acumula_compara_n: directed and random checks of acumula_compara_n against a cycle-level credit model
module tb_acumula_compara_n;
  localparam int TL = 8;
  localparam int MAXC = 63;
  logic CLK = 1'b0, rst = 1'b1, rstC = 1'b0, moeda_valida = 1'b0, compra = 1'b0;
  logic [2:0] VM = '0;
  logic [4:0] vProduto = '0;
  logic LP, DM, rejeita, ocupado;
  logic [5:0] vTotal, vTroco;
  int nCmp = 0, nErr = 0;
  int mPh = 0, mTot = 0, mTro = 0, mIdle = 0, mPre = 0, mRej = 0;

  acumula_compara_n #(.VALOR_W(6), .MOEDA_W(3), .PRECO_W(5), .TEMPO_LIMITE(TL), .TEMPO_W(7)) dut (
    .CLK(CLK), .rst(rst), .rstC(rstC), .moeda_valida(moeda_valida), .VM(VM), .compra(compra),
    .vProduto(vProduto), .LP(LP), .DM(DM), .rejeita(rejeita), .vTotal(vTotal), .vTroco(vTroco),
    .ocupado(ocupado));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    assert (got === exp) else begin
      nErr++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // phase: 0 idle, 1 collecting credit, 2 releasing product, 3 refunding
  task automatic modelReset();
    mPh = 0; mTot = 0; mTro = 0; mIdle = 0; mPre = 0; mRej = 0;
  endtask

  task automatic modelStep(input int rc, input int mv, input int vm, input int cp, input int vp);
    mRej = 0;
    if (mPh == 0) begin
      if (mv != 0 && vm != 0) begin mTot = vm; mIdle = 0; mPh = 1; end
    end else if (mPh == 1) begin
      if (rc != 0) begin mPh = 3; mRej = mv; end
      else if (cp != 0 && vp != 0 && mTot >= vp) begin mPh = 2; mPre = vp; mRej = mv; end
      else if (mIdle == TL - 1) begin mPh = 3; mRej = mv; end
      else if (mv != 0 && mTot + vm <= MAXC) begin mTot += vm; mIdle = 0; end
      else begin mRej = mv; mIdle++; end
    end else begin
`ifdef TROCO_EN
      mTro = (mPh == 2) ? mTot - mPre : mTot;
`else
      mTro = (mPh == 2) ? 0 : mTot;
`endif
      mTot = 0; mPh = 0; mRej = mv;
    end
  endtask

  task automatic checkAll();
    chk("LP", LP, mPh == 2);
    chk("DM", DM, mPh == 3);
    chk("rejeita", rejeita, mRej);
    chk("vTotal", vTotal, mTot);
    chk("vTroco", vTroco, mTro);
    chk("ocupado", ocupado, mPh != 0);
  endtask

  task automatic cyc(input int rc, input int mv, input int vm, input int cp, input int vp);
    rstC = 1'(rc); moeda_valida = 1'(mv); VM = 3'(vm); compra = 1'(cp); vProduto = 5'(vp);
    @(posedge CLK);
    if (rst) modelReset(); else modelStep(rc, mv, vm, cp, vp);
    #1;
    checkAll();
  endtask

  task automatic coin(input int v); cyc(0, 1, v, 0, 0); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0); endtask

  initial begin
    // reset held while every input is active
    repeat (3) cyc(1, 1, 5, 1, 7);
    chk("rst_ocupado", ocupado, 0);
    rstC = 0; moeda_valida = 0; compra = 0;
    @(negedge CLK); rst = 1'b0;
    idle();
    chk("rel_vTotal", vTotal, 0);
    // exact purchase
    coin(5); coin(2);
    chk("exact_total", vTotal, 7);
    cyc(0, 0, 0, 1, 7);
    chk("exact_LP", LP, 1);
    idle();
    chk("exact_LP_off", LP, 0);
    chk("exact_total0", vTotal, 0);
    chk("exact_troco", vTroco, 0);
    chk("exact_ocupado", ocupado, 0);
    // purchase with change
    coin(7); coin(7); coin(3);
    chk("chg_total", vTotal, 17);
    cyc(0, 0, 0, 1, 12);
    chk("chg_LP", LP, 1);
    idle();
`ifdef TROCO_EN
    chk("chg_troco", vTroco, 5);
`else
    chk("chg_troco", vTroco, 0);
`endif
    // insufficient credit, then topped up
    coin(4);
    cyc(0, 0, 0, 1, 9);
    chk("insuf_LP", LP, 0);
    chk("insuf_total", vTotal, 4);
    coin(5);
    chk("insuf_total9", vTotal, 9);
    cyc(0, 0, 0, 1, 9);
    chk("insuf_LP2", LP, 1);
    idle();
    chk("insuf_troco", vTroco, 0);
    // inactivity timeout
    coin(3);
    repeat (7) idle();
    chk("tmo_DM_early", DM, 0);
    idle();
    chk("tmo_DM", DM, 1);
    idle();
    chk("tmo_troco", vTroco, 3);
    chk("tmo_total", vTotal, 0);
    // a coin every 7 cycles keeps the timer from expiring
    coin(1);
    for (int k = 0; k < 4; k++) begin
      repeat (6) begin idle(); chk("keep_DM", DM, 0); end
      coin(1);
    end
    chk("keep_total", vTotal, 5);
    cyc(1, 0, 0, 0, 0);
    chk("cancel_DM", DM, 1);
    idle();
    chk("cancel_troco", vTroco, 5);
    // overflow rejection at 60 credit
    repeat (8) coin(7);
    coin(4);
    chk("ovf_total60", vTotal, 60);
    coin(7);
    chk("ovf_rej", rejeita, 1);
    chk("ovf_total", vTotal, 60);
    // coin together with cancel
    cyc(1, 1, 2, 0, 0);
    chk("rc_DM", DM, 1);
    chk("rc_rej", rejeita, 1);
    idle();
    chk("rc_troco", vTroco, 60);
    chk("rc_total", vTotal, 0);
    // asynchronous reset mid-transaction
    coin(3); coin(2);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(negedge CLK); rst = 1'b0;
    repeat (3) begin idle(); chk("arst_DM", DM, 0); end
    // random traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom % 25) == 0, ($urandom % 3) == 0, $urandom % 8, ($urandom % 6) == 0, $urandom_range(0, 31));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
